decode_regfile: RTL
===================

# decode_regfile

Parametrised Y86-64 decode stage with an integrated, reset-able register file and D-to-E pipeline register. It maps D-stage instruction fields to source/destination IDs, reads operands through write-back bypass, and latches the result into E-stage registers. Stall and bubble controls come from pipeline control. It sits between the fetch D register and the execute stage; the write-back stage drives its two write ports.

## Interface
- DATA_W, 64, register and operand width
- NREGS, 15, architectural registers; IDs 0..NREGS-1 are valid
- ID_W, 4, register-ID width; all-ones (15 at default) means "none"
- SP_ID, 4, stack-pointer register ID
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- D_icode, D_ifun  in  4 each  D-stage instruction code/function
- D_rA, D_rB  in  ID_W each  D-stage register fields
- D_valP  in  DATA_W  D-stage incremented PC
- E_stall  in  1  hold E register contents
- E_bubble  in  1  load a nop into the E register
- W_dstE, W_dstM  in  ID_W each  write-back destinations
- W_valE, W_valM  in  DATA_W each  write-back data
- E_icode, E_ifun  out  4 each  registered instruction code/function
- E_srcA, E_srcB, E_dstE, E_dstM  out  ID_W each  registered register IDs
- E_valA, E_valB  out  DATA_W each  registered operands
- regis  out  DATA_W*NREGS  flat register-file image; register 0 in the most-significant slice

## Operation
- ID decode is combinational from D_icode. NONE is all-ones. Unlisted IDs are NONE.
  - 2 cmov: srcA=rA, dstE=rB
  - 3 irmov: dstE=rB
  - 4 rmmov: srcA=rA, srcB=rB
  - 5 mrmov: srcB=rB, dstM=rA
  - 6 OPq: srcA=rA, srcB=rB, dstE=rB
  - 8 call: srcB=SP, dstE=SP
  - 9 ret: srcA=srcB=dstE=SP
  - 10 push: srcA=rA, srcB=SP, dstE=SP
  - 11 pop: srcA=srcB=dstE=SP, dstM=rA
- Operand read:
  - An ID of NONE or any ID >= NREGS reads 0.
  - Otherwise the operand is the register value, with same-cycle write-back bypass.
  - If the ID equals W_dstM, the operand is W_valM.
  - Else if the ID equals W_dstE, the operand is W_valE.
  - Else the operand is the stored register value.
- valA for icode 8 (call) is D_valP, regardless of srcA.
- Register write on each clock edge:
  - reg[W_dstE] <= W_valE and reg[W_dstM] <= W_valM.
  - IDs of NONE or >= NREGS are ignored.
  - If W_dstE == W_dstM, the M port wins, so popq %rsp yields the popped value.
- E register update each edge:
  - E_bubble=1: load the nop image (icode=1, ifun=0, all IDs NONE, valA=valB=0). Bubble has priority over stall.
  - E_stall=1 and E_bubble=0: hold the current contents.
  - Otherwise: load the decoded fields and operands.
- regis reflects stored register state only; it is not bypassed.

## Timing
- Asynchronous reset, effective immediately while rst=1:
  - all registers become 0, and regis=0
  - the E register takes the nop image
- Latency: D inputs appear on E_* one edge later.
- Write-back data appears on regis one edge after it is presented on the W ports. A same-cycle read sees it combinationally through the bypass.
- Write ports are not suppressed by E_stall or E_bubble; the register file always commits.
- Reset asserted mid-operation discards pending writes on the same edge. The first edge after rst deasserts behaves as a normal cycle.

## Test plan
- Reset: assert rst with nonzero prior state -> regis=0; E_icode=1; E_srcA=E_dstE=15; E_valA=0, without any clock edge.
- Write then read:
  - W_dstE=3, W_valE=0x1234, then next cycle D_icode=6, rA=3, rB=3 -> E_valA=E_valB=0x1234, E_dstE=3.
  - regis slice 3 = 0x1234.
- Bypass priority: registers 4=0x100, D_icode=11 (pop), rA=4, W_dstE=W_dstM=4, W_valE=0x108, W_valM=0xBEEF in the same cycle -> E_valA=E_valB=0xBEEF; afterwards reg4=0xBEEF.
- Call: D_icode=8, D_valP=0x40, reg4=0x200 -> E_valA=0x40, E_valB=0x200, E_dstE=4, E_srcA=15.
- Stall/bubble:
  - Load an OPq; then E_stall=1 with new D inputs for 2 cycles -> E_* unchanged.
  - Then E_stall=1 and E_bubble=1 -> nop image.
  - Writes with W_dstE=2 during the stall still update reg2.
- Invalid IDs: rA=15, W_dstE=15, W_valE=0xFF -> no register changes; operand 0.

Source files
------------

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: register-ID decode, register file with write-back bypass,
// and the D-to-E pipeline register.
module decode_regfile #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int ID_W   = 4,
  parameter int SP_ID  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              D_icode,
  input  logic [3:0]              D_ifun,
  input  logic [ID_W-1:0]         D_rA,
  input  logic [ID_W-1:0]         D_rB,
  input  logic [DATA_W-1:0]       D_valP,
  input  logic                    E_stall,
  input  logic                    E_bubble,
  input  logic [ID_W-1:0]         W_dstE,
  input  logic [ID_W-1:0]         W_dstM,
  input  logic [DATA_W-1:0]       W_valE,
  input  logic [DATA_W-1:0]       W_valM,
  output logic [3:0]              E_icode,
  output logic [3:0]              E_ifun,
  output logic [ID_W-1:0]         E_srcA,
  output logic [ID_W-1:0]         E_srcB,
  output logic [ID_W-1:0]         E_dstE,
  output logic [ID_W-1:0]         E_dstM,
  output logic [DATA_W-1:0]       E_valA,
  output logic [DATA_W-1:0]       E_valB,
  output logic [DATA_W*NREGS-1:0] regis
);

  localparam logic [ID_W-1:0] RNONE = '1;
  localparam logic [ID_W-1:0] RSP   = ID_W'(SP_ID);

  localparam logic [3:0] I_NOP   = 4'd1;
  localparam logic [3:0] I_CMOV  = 4'd2;
  localparam logic [3:0] I_IRMOV = 4'd3;
  localparam logic [3:0] I_RMMOV = 4'd4;
  localparam logic [3:0] I_MRMOV = 4'd5;
  localparam logic [3:0] I_OPQ   = 4'd6;
  localparam logic [3:0] I_CALL  = 4'd8;
  localparam logic [3:0] I_RET   = 4'd9;
  localparam logic [3:0] I_PUSH  = 4'd10;
  localparam logic [3:0] I_POP   = 4'd11;

  logic [DATA_W-1:0] rf [NREGS];

  logic [ID_W-1:0]   d_srcA, d_srcB, d_dstE, d_dstM;
  logic [DATA_W-1:0] d_valA, d_valB;

  // NONE is excluded explicitly so a 16-entry file never treats it as a register.
  function automatic logic id_valid(input logic [ID_W-1:0] id);
    return (id != RNONE) && (int'(id) < NREGS);
  endfunction

  function automatic logic [DATA_W-1:0] read_op(input logic [ID_W-1:0] id);
    logic [DATA_W-1:0] v;
    v = '0;
    if (id_valid(id)) begin
      for (int i = 0; i < NREGS; i++) begin
        if (id == ID_W'(i)) v = rf[i];
      end
      if (id == W_dstM)      v = W_valM;
      else if (id == W_dstE) v = W_valE;
    end
    return v;
  endfunction

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_CMOV:  begin d_srcA = D_rA; d_dstE = D_rB; end
      I_IRMOV: begin d_dstE = D_rB; end
      I_RMMOV: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOV: begin d_srcB = D_rB; d_dstM = D_rA; end
      I_OPQ:   begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      I_CALL:  begin d_srcB = RSP; d_dstE = RSP; end
      I_RET:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
      I_PUSH:  begin d_srcA = D_rA; d_srcB = RSP; d_dstE = RSP; end
      I_POP:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = D_rA; end
      default: ;
    endcase
  end

  always_comb begin
    d_valA = (D_icode == I_CALL) ? D_valP : read_op(d_srcA);
    d_valB = read_op(d_srcB);
  end

  // The M port is checked first so a pop into %rsp keeps the popped value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (W_dstM == ID_W'(i) && W_dstM != RNONE)      rf[i] <= W_valM;
        else if (W_dstE == ID_W'(i) && W_dstE != RNONE) rf[i] <= W_valE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || E_bubble) begin
      E_icode <= I_NOP;
      E_ifun  <= 4'd0;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_valA  <= '0;
      E_valB  <= '0;
    end else if (!E_stall) begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regis
    assign regis[DATA_W*(NREGS-1-g) +: DATA_W] = rf[g];
  end

endmodule
